driver_sout_reader: RTL and testbench

Readback receiver for the LED driver daisy-chain SOUT path: the far end of the serial stream that `driver_controller` shifts into the drivers. It steps `driver_sout_mux` across all drivers, deserializes one word per driver from `driver_sout` by following the controller's `driver_sclk`/`driver_lat` activity, and compares each word against the expected configuration. It sits beside `driver_controller` in the top level and gives the team a per-driver pass/fail mask for configuration readback.

---
 rtl/driver_sout_reader.sv | 190 +++++++++++++++++++
 tb/tb_driver_sout_reader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/driver_sout_reader.sv
// Readback receiver for the LED driver SOUT daisy chain: walks the SOUT mux, deserializes one word per driver and flags mismatches.
// Optional capture outputs are enabled by defining SOUT_READER_CAPTURE_EN; NB_DRIVERS must be <= 32.
module driver_sout_reader #(
    parameter int unsigned WORD_WIDTH     = 48,
    parameter int unsigned NB_DRIVERS     = 30,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  driver_sclk,
    input  logic                  driver_lat,
    input  logic                  driver_sout,
    output logic [4:0]            driver_sout_mux,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] expected_word,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           mismatch_mask,
    output logic                  timeout,
    output logic [WORD_WIDTH-1:0] captured_word,
    output logic                  captured_valid
);

    localparam int unsigned MUX_W = 5;
    localparam int unsigned CNT_W = $clog2(WORD_WIDTH + 1);
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_SHIFT, S_COMPARE, S_NEXT, S_FINISH
    } state_t;

    state_t state_q, state_d;

    logic sclk_q, sclk_qq, lat_q, lat_qq, sout_q;
    logic sclk_rise, lat_fall, lat_rise, wd_event, wd_hit, cnt_full, last_drv;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
    logic [MUX_W-1:0]      mux_d;
    logic                  busy_d, done_d, timeout_d;
    logic [31:0]           mask_d;

    // Input stage: same clock domain, registered only for edge detection
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sclk_q  <= 1'b0;
            sclk_qq <= 1'b0;
            lat_q   <= 1'b0;
            lat_qq  <= 1'b0;
            sout_q  <= 1'b0;
        end else begin
            sclk_q  <= driver_sclk;
            sclk_qq <= sclk_q;
            lat_q   <= driver_lat;
            lat_qq  <= lat_q;
            sout_q  <= driver_sout;
        end
    end

    assign sclk_rise = sclk_q & ~sclk_qq;
    assign lat_fall  = ~lat_q & lat_qq;
    assign lat_rise  = lat_q & ~lat_qq;
    assign wd_event  = sclk_rise | lat_fall | lat_rise;
    assign wd_hit    = (wd_q == WD_W'(TIMEOUT_CYCLES)) && !wd_event;
    assign cnt_full  = (cnt_q == CNT_W'(WORD_WIDTH));
    assign last_drv  = (driver_sout_mux == MUX_W'(NB_DRIVERS - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_ARM;
            S_ARM: begin
                if (lat_fall)    state_d = S_SHIFT;
                else if (wd_hit) state_d = S_FINISH;
            end
            S_SHIFT: begin
                if (cnt_full)      state_d = S_COMPARE;
                else if (lat_rise) state_d = S_NEXT;
                else if (wd_hit)   state_d = S_FINISH;
            end
            S_COMPARE: state_d = S_NEXT;
            S_NEXT:    state_d = last_drv ? S_FINISH : S_ARM;
            S_FINISH:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath
    always_comb begin
        mux_d     = driver_sout_mux;
        busy_d    = busy;
        done_d    = (state_d == S_FINISH);
        mask_d    = mismatch_mask;
        timeout_d = timeout;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        wd_d      = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d    = '0;
                    timeout_d = 1'b0;
                    mux_d     = '0;
                    busy_d    = 1'b1;
                end
            end
            S_ARM: begin
                if (lat_fall) begin
                    cnt_d = '0;
                end else if (wd_hit) begin
                    timeout_d               = 1'b1;
                    mask_d[driver_sout_mux] = 1'b1;
                end
            end
            S_SHIFT: begin
                if (!cnt_full) begin
                    if (lat_rise) begin
                        mask_d[driver_sout_mux] = 1'b1;
                    end else if (wd_hit) begin
                        timeout_d               = 1'b1;
                        mask_d[driver_sout_mux] = 1'b1;
                    end else if (sclk_rise) begin
                        shreg_d = {shreg_q[WORD_WIDTH-2:0], sout_q};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_COMPARE: begin
                if (shreg_q != expected_word) mask_d[driver_sout_mux] = 1'b1;
            end
            S_NEXT: begin
                if (!last_drv) mux_d = driver_sout_mux + MUX_W'(1);
            end
            S_FINISH: busy_d = 1'b0;
            default: ;
        endcase

        // Watchdog runs only while waiting on the controller, restarting on any activity or state entry
        if ((state_q == S_ARM || state_q == S_SHIFT) && state_d == state_q && !wd_event)
            wd_d = wd_q + WD_W'(1);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            driver_sout_mux <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            mismatch_mask   <= '0;
            timeout         <= 1'b0;
            cnt_q           <= '0;
            wd_q            <= '0;
            shreg_q         <= '0;
        end else begin
            driver_sout_mux <= mux_d;
            busy            <= busy_d;
            done            <= done_d;
            mismatch_mask   <= mask_d;
            timeout         <= timeout_d;
            cnt_q           <= cnt_d;
            wd_q            <= wd_d;
            shreg_q         <= shreg_d;
        end
    end

`ifdef SOUT_READER_CAPTURE_EN
    logic cap_load;
    assign cap_load = (state_q == S_COMPARE);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            captured_word  <= '0;
            captured_valid <= 1'b0;
        end else begin
            captured_valid <= cap_load;
            if (cap_load) captured_word <= shreg_q;
        end
    end
`else
    assign captured_word  = '0;
    assign captured_valid = 1'b0;
`endif

endmodule

// File: tb/tb_driver_sout_reader.sv
// Directed bench for driver_sout_reader: a scenario table driven through a daisy-chain model, plus reset corner cases.
module tb_driver_sout_reader;

    localparam int unsigned WW = 48;
    localparam int unsigned NB = 30;
    localparam int unsigned TO = 64;
    localparam logic [WW-1:0] REF = 48'hA5A5_0F0F_3C3C;

    logic          clk = 1'b0;
    logic          nrst, driver_sclk, driver_lat, driver_sout, start;
    logic [4:0]    driver_sout_mux;
    logic [WW-1:0] expected_word, captured_word;
    logic          busy, done, timeout, captured_valid;
    logic [31:0]   mismatch_mask;

    driver_sout_reader #(.WORD_WIDTH(WW), .NB_DRIVERS(NB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .nrst(nrst), .driver_sclk(driver_sclk), .driver_lat(driver_lat),
        .driver_sout(driver_sout), .driver_sout_mux(driver_sout_mux), .start(start),
        .expected_word(expected_word), .busy(busy), .done(done),
        .mismatch_mask(mismatch_mask), .timeout(timeout),
        .captured_word(captured_word), .captured_valid(captured_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          flip;
        int          shrt;
        int          stop;
        int          mid;
        int          cap;
        logic [31:0] mask;
        logic        tmo;
        logic [4:0]  mux;
    } vec_t;

    vec_t vecs[6];

    int n_pass = 0, n_total = 0;
    int done_cnt, busy_drop, cap_cnt;
    logic in_scan = 1'b0, cap_nz;
    logic [WW-1:0] cap8;
    int cur_flip, cur_shrt, cur_mid;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Advance one clock and update the running monitors
    task automatic tick();
        @(posedge clk); #1;
        if (done) done_cnt++;
        if (in_scan && !busy) busy_drop++;
        if (done) in_scan = 1'b0;
        if (captured_valid) begin
            cap_cnt++;
            if (cap_cnt == 8) cap8 = captured_word;
        end
        if (captured_word != '0) cap_nz = 1'b1;
    endtask

    task automatic lat_pulse();
        driver_lat = 1'b1; repeat (4) tick();
        driver_lat = 1'b0; repeat (2) tick();
    endtask

    // Chain model for one driver: lat pulse then its word, MSB first
    task automatic run_driver(input int idx);
        logic [WW-1:0] w;
        int n;
        lat_pulse();
        check("mux_sel", driver_sout_mux, idx);
        w = (idx == cur_flip) ? (REF ^ WW'(1)) : REF;
        n = (idx == cur_shrt) ? 20 : WW;
        for (int b = 0; b < n; b++) begin
            driver_sout = w[WW-1-b];
            start = (idx == cur_mid && b == 10);
            tick();
            start = 1'b0;
            driver_sclk = 1'b1; tick(); tick();
            driver_sclk = 1'b0; tick();
        end
        repeat (4) tick();
    endtask

    task automatic run_scan(input vec_t v);
        int t0;
        done_cnt = 0; busy_drop = 0; cap_cnt = 0; cap8 = '0; cap_nz = 1'b0;
        cur_flip = v.flip; cur_shrt = v.shrt; cur_mid = v.mid;
        start = 1'b1; tick(); start = 1'b0;
        check("busy_rise", busy, 1);
        in_scan = 1'b1;
        for (int i = 0; i < v.stop; i++) run_driver(i);
        if (v.stop >= int'(NB)) lat_pulse();
        t0 = 0;
        while (done_cnt == 0 && t0 < 300) begin tick(); t0++; end
        check("done_seen", done_cnt, 1);
        if (v.tmo) check("timeout_latency", (t0 >= 55 && t0 <= 85), 1);
        repeat (3) tick();
        check("done_once", done_cnt, 1);
        check("mask", mismatch_mask, v.mask);
        check("timeout", timeout, v.tmo);
        check("mux_final", driver_sout_mux, v.mux);
        check("busy_fall", busy, 0);
        check("busy_held", busy_drop, 0);
        if (v.cap != 0) begin
`ifdef SOUT_READER_CAPTURE_EN
            check("cap_count", cap_cnt, NB);
            check("cap_word8", cap8, REF ^ WW'(1));
`else
            check("cap_count", cap_cnt, 0);
            check("cap_nonzero", cap_nz, 0);
`endif
        end
        in_scan = 1'b0;
    endtask

    initial begin
        vecs[0] = '{flip: -1, shrt: -1, stop: 30, mid: -1, cap: 0, mask: 32'h0000_0000, tmo: 1'b0, mux: 5'd29};
        vecs[1] = '{flip:  7, shrt: -1, stop: 30, mid: -1, cap: 1, mask: 32'h0000_0080, tmo: 1'b0, mux: 5'd29};
        vecs[2] = '{flip: -1, shrt:  3, stop: 30, mid: -1, cap: 0, mask: 32'h0000_0008, tmo: 1'b0, mux: 5'd29};
        vecs[3] = '{flip: -1, shrt: -1, stop: 12, mid: -1, cap: 0, mask: 32'h0000_1000, tmo: 1'b1, mux: 5'd12};
        vecs[4] = '{flip:  0, shrt: 29, stop: 30, mid: -1, cap: 0, mask: 32'h2000_0001, tmo: 1'b0, mux: 5'd29};
        vecs[5] = '{flip:  7, shrt: -1, stop: 30, mid: 10, cap: 0, mask: 32'h0000_0080, tmo: 1'b0, mux: 5'd29};

        nrst = 1'b0; driver_sclk = 1'b0; driver_lat = 1'b0; driver_sout = 1'b0; start = 1'b0;
        expected_word = REF;
        done_cnt = 0; busy_drop = 0; cap_cnt = 0; cap8 = '0; cap_nz = 1'b0;
        repeat (3) tick();
        check("rst_mux", driver_sout_mux, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mask", mismatch_mask, 0);
        check("rst_timeout", timeout, 0);
        check("rst_cap_word", captured_word, 0);
        check("rst_cap_valid", captured_valid, 0);
        nrst = 1'b1;
        repeat (2) tick();

        for (int v = 0; v < 6; v++) run_scan(vecs[v]);

        // Reset in the middle of a scan returns everything to idle without a done pulse
        cur_flip = 2; cur_shrt = -1; cur_mid = -1;
        done_cnt = 0; busy_drop = 0;
        start = 1'b1; tick(); start = 1'b0;
        in_scan = 1'b1;
        for (int i = 0; i < 5; i++) run_driver(i);
        check("pre_rst_mask", mismatch_mask, 32'h0000_0004);
        check("pre_rst_busy", busy, 1);
        driver_lat = 1'b1; tick(); tick();
        #2 nrst = 1'b0; in_scan = 1'b0;
        #1;
        check("mid_rst_mux", driver_sout_mux, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_mask", mismatch_mask, 0);
        check("mid_rst_timeout", timeout, 0);
        check("mid_rst_done", done, 0);
        repeat (3) tick();
        check("mid_rst_no_done", done_cnt, 0);
        nrst = 1'b1; driver_lat = 1'b0;
        repeat (3) tick();
        check("post_rst_busy", busy, 0);

        run_scan(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
